uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer downstream of the UART receiver. Captures each byte the

---
 rtl/uart_rx_fifo.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between the UART receiver and a Wishbone slave.
// Registers: 0x00 STAT (RO), 0x08 DATA (RO, pops), 0x10 CTRL (flush / clear overflow).
// Optional build macro UART_RX_FIFO_IRQ_EN adds a CTRL threshold field and a level irq_o.
`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 32
`endif

module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  input  logic                   fifo_stb_i,
  input  logic                   fifo_we_i,
  input  logic [`ADR_WIDTH-1:0]  fifo_adr_i,
  input  logic [`DAT_WIDTH-1:0]  fifo_dat_i,
  output logic [`DAT_WIDTH-1:0]  fifo_dat_o,
  output logic                   fifo_ack_o,
  output logic                   fifo_err_o,
  output logic                   irq_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [7:0] A_STAT = 8'h00;
  localparam logic [7:0] A_DATA = 8'h08;
  localparam logic [7:0] A_CTRL = 8'h10;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state;
  logic [7:0]              mem [DEPTH];
  logic [ADDR_W-1:0]       wr_ptr;
  logic [ADDR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    overflow;
  logic                    r_ack;
  logic                    r_err;
  logic [`DAT_WIDTH-1:0]   rd_val;
`ifdef UART_RX_FIFO_IRQ_EN
  logic [CNT_W-1:0]        thresh;
`endif

  logic       empty, full, access, sel_stat, sel_data, sel_ctrl, dec_err;
  logic       push, pop, flush, clr_ovf, ovf_set;
  logic [7:0] adr;

  assign adr      = fifo_adr_i[7:0];
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign access   = (state == S_IDLE) && fifo_stb_i;
  assign sel_stat = (adr == A_STAT);
  assign sel_data = (adr == A_DATA);
  assign sel_ctrl = (adr == A_CTRL);
  assign dec_err  = !(sel_stat || sel_data || sel_ctrl);
  assign pop      = access && !fifo_we_i && sel_data && !empty;
  assign flush    = access && fifo_we_i && sel_ctrl && fifo_dat_i[0];
  assign clr_ovf  = access && fifo_we_i && sel_ctrl && fifo_dat_i[1];
  // Full-check uses the pre-pop count, so a drop stands even if a pop lands the same cycle.
  assign push     = rx_valid_i && !full && !flush;
  assign ovf_set  = rx_valid_i && full && !flush;

  assign fifo_ack_o = r_ack && fifo_stb_i;
  assign fifo_err_o = r_err && fifo_stb_i;

  // Unused upper address/data bits, gathered so they are visibly consumed.
  logic unused_bits;
`ifdef UART_RX_FIFO_IRQ_EN
  assign unused_bits = ^{fifo_adr_i[`ADR_WIDTH-1:8], fifo_dat_i[`DAT_WIDTH-1:ADDR_W+9],
                         fifo_dat_i[7:2]};
`else
  assign unused_bits = ^{fifo_adr_i[`ADR_WIDTH-1:8], fifo_dat_i[`DAT_WIDTH-1:2]};
`endif

  // Read data mux for the addressed register.
  always_comb begin
    rd_val = '0;
    if (sel_stat) begin
      rd_val[ADDR_W+3:0] = {overflow, count, full, empty};
    end else if (sel_data) begin
      if (!empty) rd_val[8:0] = {1'b1, mem[rd_ptr]};
    end else if (sel_ctrl) begin
`ifdef UART_RX_FIFO_IRQ_EN
      rd_val[ADDR_W+8:8] = thresh;
`endif
    end
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= ovf_set || (overflow && !clr_ovf);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Byte storage; written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rx_data_i;
  end

  // Wishbone slave FSM: one access per strobe, response held until strobe drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      fifo_dat_o <= '0;
`ifdef UART_RX_FIFO_IRQ_EN
      thresh     <= CNT_W'(1);
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_stb_i) begin
            state      <= S_WAIT;
            r_ack      <= !dec_err;
            r_err      <= dec_err;
            fifo_dat_o <= (fifo_we_i || dec_err) ? '0 : rd_val;
`ifdef UART_RX_FIFO_IRQ_EN
            if (fifo_we_i && sel_ctrl) thresh <= fifo_dat_i[ADDR_W+8:8];
`endif
          end
        end
        S_WAIT: begin
          if (!fifo_stb_i) begin
            state <= S_IDLE;
            r_ack <= 1'b0;
            r_err <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  // Level interrupt: occupancy at/above threshold, or overflow pending.
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= ((count >= thresh) && (thresh != '0)) || overflow;
  end
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed Wishbone/receiver stimulus, scoreboard-checked responses.
`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 32
`endif

module tb_uart_rx_fifo;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  stb;
  logic                  we;
  logic [`ADR_WIDTH-1:0] adr;
  logic [`DAT_WIDTH-1:0] wdat;
  logic [`DAT_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  err_o;
  logic                  irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] dat;
    bit          err;
    bit          chk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .fifo_stb_i (stb),
    .fifo_we_i  (we),
    .fifo_adr_i (adr),
    .fifo_dat_i (wdat),
    .fifo_dat_o (dat_o),
    .fifo_ack_o (ack_o),
    .fifo_err_o (err_o),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  // Monitor: every sampled response consumes one expected entry.
  always @(negedge clk) begin
    if (!rst && (ack_o || err_o)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp ack=%b err=%b dat=%h", ack_o, err_o, dat_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (err_o !== mon_e.err || ack_o !== !mon_e.err ||
            (mon_e.chk && dat_o !== mon_e.dat)) begin
          errors++;
          $display("FAIL %s got ack=%b err=%b dat=%h want err=%b dat=%h",
                   mon_e.name, ack_o, err_o, dat_o, mon_e.err, mon_e.dat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // One Wishbone access; optional receiver strobe on the decode edge.
  task automatic wb(input bit w, input logic [7:0] a, input logic [31:0] d,
                    input bit cpush, input logic [7:0] cbyte,
                    input logic [31:0] edat, input bit eerr, input string name);
    exp_t e;
    bit   got;
    e.name = name;
    e.dat  = edat;
    e.err  = eerr;
    e.chk  = !w && !eerr;
    exp_q.push_back(e);
    stb      = 1'b1;
    we       = w;
    adr      = `ADR_WIDTH'(a);
    wdat     = `DAT_WIDTH'(d);
    rx_valid = cpush;
    rx_data  = cbyte;
    tick();
    rx_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack_o || err_o) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no ack/err within 20 cycles", name);
      if (exp_q.size() != 0) e = exp_q.pop_front();
    end
    tick();
    stb = 1'b0;
    we  = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] edat, input string name);
    wb(1'b0, a, 32'h0, 1'b0, 8'h00, edat, 1'b0, name);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string name);
    wb(1'b1, a, d, 1'b0, 8'h00, 32'h0, 1'b0, name);
  endtask

  task automatic chk_irq(input bit exp, input string name);
    checks++;
    if (irq !== exp) begin
      errors++;
      $display("FAIL %s irq_o=%b want %b", name, irq, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk_irq(1'b0, "reset_irq");
    rd(8'h00, 32'h001, "reset_stat");
    rd(8'h08, 32'h000, "reset_data_empty");
    rd(8'h00, 32'h001, "reset_stat_again");

    // Three bytes in, three out
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    rd(8'h00, 32'h00C, "stat_cnt3");
    rd(8'h08, 32'h141, "data_41");
    rd(8'h08, 32'h142, "data_42");
    rd(8'h08, 32'h143, "data_43");
    rd(8'h08, 32'h000, "data_empty");
    rd(8'h00, 32'h001, "stat_empty");

    // Overflow: 17 bytes into 16 entries
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    rd(8'h00, 32'h0C2, "stat_full_ovf");
    for (int i = 0; i < 16; i++) rd(8'h08, 32'h100 + 32'(i), "data_ovf_seq");
    rd(8'h08, 32'h000, "data_after_drain");
    rd(8'h00, 32'h081, "stat_ovf_sticky");
    wr(8'h10, 32'h2, "ctrl_clr_ovf");
    rd(8'h00, 32'h001, "stat_ovf_cleared");

    // Concurrent push/pop at count 15, then 40 more with pointer wrap
    for (int i = 0; i < 15; i++) push_byte(8'(8'h20 + i));
    rd(8'h00, 32'h03C, "stat_cnt15");
    wb(1'b0, 8'h08, 32'h0, 1'b1, 8'h2F, 32'h120, 1'b0, "data_pushpop");
    rd(8'h00, 32'h03C, "stat_cnt15_kept");
    for (int k = 0; k < 40; k++)
      wb(1'b0, 8'h08, 32'h0, 1'b1, 8'(8'h30 + k), 32'h121 + 32'(k), 1'b0, "data_wrap");
    rd(8'h00, 32'h03C, "stat_after_wrap");

    // Flush with concurrent push
    wr(8'h10, 32'h1, "ctrl_flush");
    rd(8'h00, 32'h001, "stat_flushed");
    for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
    rd(8'h00, 32'h014, "stat_cnt5");
    wb(1'b1, 8'h10, 32'h1, 1'b1, 8'h65, 32'h0, 1'b0, "ctrl_flush_push");
    rd(8'h00, 32'h001, "stat_flush_wins");
    rd(8'h08, 32'h000, "data_flush_empty");

    // Flush while full with a would-be overflow: overflow untouched
    for (int i = 0; i < 16; i++) push_byte(8'(8'h70 + i));
    rd(8'h00, 32'h042, "stat_full_noovf");
    wb(1'b1, 8'h10, 32'h1, 1'b1, 8'h80, 32'h0, 1'b0, "ctrl_flush_full");
    rd(8'h00, 32'h001, "stat_flush_no_ovf");

    // Clear-overflow racing a new overflow: overflow stays set
    for (int i = 0; i < 16; i++) push_byte(8'(8'h70 + i));
    push_byte(8'h80);
    rd(8'h00, 32'h0C2, "stat_ovf2");
    wb(1'b1, 8'h10, 32'h2, 1'b1, 8'h81, 32'h0, 1'b0, "ctrl_clr_race");
    rd(8'h00, 32'h0C2, "stat_ovf_race_set");
    wr(8'h10, 32'h2, "ctrl_clr_ovf2");
    rd(8'h00, 32'h042, "stat_ovf2_cleared");
    wr(8'h10, 32'h3, "ctrl_flush_clr");
    rd(8'h00, 32'h001, "stat_clean");

    // Push and pop together on an empty FIFO
    wb(1'b0, 8'h08, 32'h0, 1'b1, 8'h99, 32'h000, 1'b0, "data_empty_push");
    rd(8'h00, 32'h004, "stat_cnt1");
    rd(8'h08, 32'h199, "data_99");
    rd(8'h00, 32'h001, "stat_empty2");

    // Bad address and ignored writes
    push_byte(8'hB0); push_byte(8'hB1);
    rd(8'h00, 32'h008, "stat_cnt2");
    wb(1'b0, 8'h18, 32'h0, 1'b0, 8'h00, 32'h0, 1'b1, "bad_adr_read");
    wb(1'b1, 8'h18, 32'h3, 1'b0, 8'h00, 32'h0, 1'b1, "bad_adr_write");
    wr(8'h08, 32'hFF, "data_write_ign");
    wr(8'h00, 32'hFF, "stat_write_ign");
    rd(8'h00, 32'h008, "stat_unchanged");
    rd(8'h08, 32'h1B0, "data_B0");
    rd(8'h08, 32'h1B1, "data_B1");

    // Threshold interrupt
`ifdef UART_RX_FIFO_IRQ_EN
    rd(8'h10, 32'h100, "ctrl_thresh_reset");
    wr(8'h10, 32'h400, "ctrl_thresh4");
    rd(8'h10, 32'h400, "ctrl_thresh_rb");
    for (int i = 0; i < 3; i++) push_byte(8'(8'hA0 + i));
    tick();
    chk_irq(1'b0, "irq_below");
    push_byte(8'hA3);
    chk_irq(1'b0, "irq_lag");
    tick();
    chk_irq(1'b1, "irq_at_thresh");
    rd(8'h08, 32'h1A0, "data_A0");
    chk_irq(1'b0, "irq_after_pop");
`else
    rd(8'h10, 32'h000, "ctrl_read_zero");
    wr(8'h10, 32'h400, "ctrl_thresh_ign");
    rd(8'h10, 32'h000, "ctrl_read_zero2");
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA0 + i));
    tick();
    chk_irq(1'b0, "irq_tied_low");
    rd(8'h08, 32'h1A0, "data_A0");
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
